// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if
// Purpose : bundles the request/grant/mux-select signals of the 4-way
//           round-robin mux arbiter.
// Signals :
//   req[3:0]   requester -> arbiter, held high for the whole tenure
//   grant[3:0] arbiter -> requesters, one-hot registered grant, 0 when idle
//   S1, S0     arbiter -> 4:1 mux select, {S1,S0} = owner index
//   busy       arbiter -> mux, high while a grant is active (qualifies Y)
//   dbg_state  arbiter FSM state (0 = IDLE, 1 = OWN), observation only
// Modports: master = requester/mux side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       S1;
    logic       S0;
    logic       busy;
    logic       dbg_state;

    modport master (
        output req,
        input  grant,
        input  S1,
        input  S0,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  req,
        output grant,
        output S1,
        output S0,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Purpose : 4-requester round-robin arbiter that also drives the select
//           lines of a 4:1 mux. Search order from last owner k is
//           k+1, k+2, k+3, k. Ownership is held while req[k] stays high;
//           on release the next requester is granted at the same edge.
// Ports   :
//   clk     sole clock, rising edge
//   rst     asynchronous active-high reset
//   io_arb  rr_mux_arbiter_if.slave (req in; grant, S1, S0, busy,
//           dbg_state out). All outputs come straight from registers.
// Handshake: req[i] is a level request held for the entire tenure;
//   grant[i] is the registered answer, visible one cycle after req is
//   sampled. Dropping req[i] releases the tenure at the next edge.
// Parameter: BURST_MAX (2..255) limits consecutive grant cycles.
// Config  : optional macro ARB_BURST_LIMIT_EN builds an 8-bit tenure
//           counter; without it tenure is unlimited and BURST_MAX is
//           only range-checked.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int unsigned BURST_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  io_arb
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    generate
        if (BURST_MAX < 2 || BURST_MAX > 255) begin : g_bad_param
            $error("rr_mux_arbiter: BURST_MAX must be in 2..255");
        end
    endgenerate

    logic [0:0] r_state;
    logic [1:0] r_owner;   // last/current owner, drives the search start
    logic [1:0] r_sel;     // mux select; separate from r_owner so reset gives 00
    logic [3:0] r_grant;
    logic       r_busy;

    logic       w_win_found;
    logic [1:0] w_win_idx;
    logic       w_limit;
    logic       w_hold;
    logic       w_start;

    // Round-robin search: k+1, k+2, k+3, then k itself (i = 4 wraps to k).
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_owner;
        for (int i = 1; i <= 4; i++) begin
            if (!w_win_found && io_arb.req[r_owner + 2'(i)]) begin
                w_win_found = 1'b1;
                w_win_idx   = r_owner + 2'(i);
            end
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] r_count;

    assign w_limit = (r_count == 8'(BURST_MAX));

    // Counts owner cycles of the current tenure; restarts at 1 on any
    // new grant, including a re-grant of the same owner after the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (w_hold) begin
            r_count <= r_count + 8'd1;
        end else if (w_start) begin
            r_count <= 8'd1;
        end else begin
            r_count <= 8'd0;
        end
    end
`else
    assign w_limit = 1'b0;
`endif

    assign w_hold  = (r_state == ST_OWN) && io_arb.req[r_owner] && !w_limit;
    assign w_start = w_win_found && !w_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd3;
            r_sel   <= 2'd0;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
        end else if (w_hold) begin
            r_state <= ST_OWN;
        end else if (w_start) begin
            // New tenure (from IDLE, handover, or limit re-grant).
            r_state <= ST_OWN;
            r_owner <= w_win_idx;
            r_sel   <= w_win_idx;
            r_grant <= 4'b0001 << w_win_idx;
            r_busy  <= 1'b1;
        end else begin
            // No requests: idle, owner and select keep their last value.
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
        end
    end

    assign io_arb.grant     = r_grant;
    assign io_arb.S1        = r_sel[1];
    assign io_arb.S0        = r_sel[0];
    assign io_arb.busy      = r_busy;
    assign io_arb.dbg_state = r_state;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Directed-vector bench for rr_mux_arbiter with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point (after the edge that captured the previous inputs).
// Structural invariants are checked on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rr_mux_arbiter_if arb_if ();

    rr_mux_arbiter #(.BURST_MAX(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (arb_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] sel, input logic b);
        check({tag, "_grant"}, 32'(arb_if.grant), 32'(g));
        check({tag, "_sel"},   32'({arb_if.S1, arb_if.S0}), 32'(sel));
        check({tag, "_busy"},  32'(arb_if.busy), 32'(b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arb_if.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    // Invariants: one-hot-or-zero grant, select matches grant, busy == |grant.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv_onehot", 32'($onehot0(arb_if.grant)), 32'd1);
            check("inv_busy", 32'(arb_if.busy), 32'(|arb_if.grant));
            check("inv_sel", 32'(arb_if.grant),
                  arb_if.busy ? 32'(4'b0001 << {arb_if.S1, arb_if.S0}) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        arb_if.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 2'b00, 1'b0);
        check("reset_state", 32'(arb_if.dbg_state), 32'd0);
        rst = 1'b0;

        // Single request and release.
        arb_if.req = 4'b0001; step();
        expect_out("single", 4'b0001, 2'b00, 1'b1);
        check("single_state", 32'(arb_if.dbg_state), 32'd1);
        arb_if.req = 4'b0000; step();
        expect_out("release", 4'b0000, 2'b00, 1'b0);
        step();
        expect_out("stay_idle", 4'b0000, 2'b00, 1'b0);

        // All requesting, each owner drops for one cycle after its grant.
        do_reset();
        arb_if.req = 4'b1111; step(); expect_out("rr0", 4'b0001, 2'b00, 1'b1);
        arb_if.req = 4'b1110; step(); expect_out("rr1", 4'b0010, 2'b01, 1'b1);
        arb_if.req = 4'b1101; step(); expect_out("rr2", 4'b0100, 2'b10, 1'b1);
        arb_if.req = 4'b1011; step(); expect_out("rr3", 4'b1000, 2'b11, 1'b1);
        arb_if.req = 4'b0111; step(); expect_out("rr4", 4'b0001, 2'b00, 1'b1);

        // Owner 2 holds, then hands over searching 3,0,1.
        do_reset();
        arb_if.req = 4'b0100; step(); expect_out("own2", 4'b0100, 2'b10, 1'b1);
        arb_if.req = 4'b0110; step(); expect_out("hold2", 4'b0100, 2'b10, 1'b1);
        arb_if.req = 4'b0010; step(); expect_out("hand1", 4'b0010, 2'b01, 1'b1);
        arb_if.req = 4'b1001; step(); expect_out("hand3", 4'b1000, 2'b11, 1'b1);
        arb_if.req = 4'b0000; step(); expect_out("idle_sel", 4'b0000, 2'b11, 1'b0);
        arb_if.req = 4'b0001; step(); expect_out("wrap0", 4'b0001, 2'b00, 1'b1);

        // Asynchronous reset mid-tenure.
        arb_if.req = 4'b1000; step(); expect_out("own3", 4'b1000, 2'b11, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 2'b00, 1'b0);
        step();
        expect_out("rst_held", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        arb_if.req = 4'b1001; step(); expect_out("post_rst", 4'b0001, 2'b00, 1'b1);
        step(); expect_out("post_rst_hold", 4'b0001, 2'b00, 1'b1);

        // Tenure limit (or unlimited tenure in the default build).
        do_reset();
        arb_if.req = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            step();
`ifdef ARB_BURST_LIMIT_EN
            if (((c / 4) % 2) == 0) expect_out("burst_a", 4'b0001, 2'b00, 1'b1);
            else                    expect_out("burst_a", 4'b0010, 2'b01, 1'b1);
`else
            expect_out("unlimited", 4'b0001, 2'b00, 1'b1);
`endif
        end
        arb_if.req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            expect_out("solo", 4'b0001, 2'b00, 1'b1);
        end

        arb_if.req = 4'b0000; step();
        expect_out("final_idle", 4'b0000, 2'b00, 1'b0);
        check("final_state", 32'(arb_if.dbg_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
